int_ctrl: RTL

Machine-mode interrupt controller sitting between the interrupt sources and the pipeline/CSR unit. It synchronises the software, timer and external interrupt lines. External edges are latched into per-source pending bits, and the block drives the mip value into the CSR unit. It also arbitrates pending-and-enabled interrupts by fixed RISC-V priority and sequences entry and exit with the pipeline through a req/ack handshake and mret.

---
 rtl/int_ctrl_pkg.sv | 27 ++
 rtl/int_ctrl_sync.sv | 38 +++
 rtl/int_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller:
// mip bit positions, mcause codes and controller FSM states.
package int_ctrl_pkg;

   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

   localparam int         CAUSE_MSB = 31;
   localparam logic [4:0] CODE_MSI  = 5'd3;
   localparam logic [4:0] CODE_MTI  = 5'd7;
   localparam logic [4:0] CODE_MEI  = 5'd11;

   typedef enum logic [1:0] {
      IC_IDLE   = 2'd0,
      IC_REQ    = 2'd1,
      IC_ACTIVE = 2'd2
   } ic_state_e;

   function automatic logic [31:0] make_cause(input logic [4:0] code);
      logic [31:0] v;
      v            = {27'd0, code};
      v[CAUSE_MSB] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/int_ctrl_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line; with EDGE set,
// the output is a one-cycle pulse on each synchronised rising edge.
module irq_sync #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_out
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   generate
      if (EDGE) begin : g_edge
         logic r_prev;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) r_prev <= 1'b0;
            else        r_prev <= r_sync;
         end
         assign o_out = r_sync & ~r_prev;
      end else begin : g_level
         assign o_out = r_sync;
      end
   endgenerate

endmodule

// File: rtl/int_ctrl.sv
// Machine-mode interrupt controller: synchronises interrupt lines, latches
// external edges, drives mip, and sequences entry/exit with the pipeline.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_EXT = 4,
   parameter int ID_W    = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_EXT-1:0] ext_irq,
   input  logic               timer_irq,
   input  logic               soft_irq,
   input  logic [NUM_EXT-1:0] ext_enable,
   input  logic               ext_claim,
   input  logic [ID_W-1:0]    ext_claim_id,
   input  logic [31:0]        mie,
   input  logic               global_int_enable,
   input  logic               int_ack,
   input  logic               mret_taken,
   output logic [31:0]        mip_out,
   output logic               int_req,
   output logic [31:0]        int_cause,
   output logic [ID_W-1:0]    ext_id,
   output logic               busy
);

   logic [NUM_EXT-1:0] w_ext_rise;
   logic               w_timer_lvl;
   logic               w_soft_lvl;
   logic [NUM_EXT-1:0] r_pending;
   logic [NUM_EXT-1:0] w_pend_en;
   logic [31:0]        w_mip;
   logic [31:0]        w_eligible;
   logic [4:0]         w_sel_code;
   logic [ID_W-1:0]    w_low_id;

   ic_state_e          r_state;
   logic               r_int_req;
   logic [31:0]        r_cause;
   logic [ID_W-1:0]    r_ext_id;
   logic               r_busy;

   irq_sync #(.EDGE(1'b0)) u_timer_sync (
      .clk(clk), .reset(reset), .i_async(timer_irq), .o_out(w_timer_lvl)
   );
   irq_sync #(.EDGE(1'b0)) u_soft_sync (
      .clk(clk), .reset(reset), .i_async(soft_irq), .o_out(w_soft_lvl)
   );

   generate
      for (genvar g = 0; g < NUM_EXT; g++) begin : g_ext
         irq_sync #(.EDGE(1'b1)) u_ext_sync (
            .clk(clk), .reset(reset), .i_async(ext_irq[g]), .o_out(w_ext_rise[g])
         );
      end
   endgenerate

   // A fresh edge on the claimed source re-arms it rather than being lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
      end else begin
         for (int i = 0; i < NUM_EXT; i++) begin
            if (w_ext_rise[i])
               r_pending[i] <= 1'b1;
            else if (ext_claim && (ext_claim_id == ID_W'(i)))
               r_pending[i] <= 1'b0;
         end
      end
   end

   assign w_pend_en = r_pending & ext_enable;

   always_comb begin
      w_mip           = '0;
      w_mip[MIP_MSIP] = w_soft_lvl;
      w_mip[MIP_MTIP] = w_timer_lvl;
      w_mip[MIP_MEIP] = |w_pend_en;
   end

   assign mip_out    = w_mip;
   assign w_eligible = w_mip & mie & {32{global_int_enable}};

   always_comb begin
      w_sel_code = CODE_MTI;
      if (w_eligible[MIP_MEIP])      w_sel_code = CODE_MEI;
      else if (w_eligible[MIP_MSIP]) w_sel_code = CODE_MSI;
   end

   always_comb begin
      w_low_id = '0;
      for (int i = NUM_EXT - 1; i >= 0; i--)
         if (w_pend_en[i]) w_low_id = ID_W'(i);
   end

   // In REQ the frozen cause is re-checked against live eligibility so a
   // vanished source withdraws the request; ack takes precedence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IC_IDLE;
         r_int_req <= 1'b0;
         r_cause   <= '0;
         r_ext_id  <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IC_IDLE: begin
               if (|w_eligible) begin
                  r_state   <= IC_REQ;
                  r_int_req <= 1'b1;
                  r_cause   <= make_cause(w_sel_code);
               end
            end
            IC_REQ: begin
               if (int_ack) begin
                  r_state   <= IC_ACTIVE;
                  r_int_req <= 1'b0;
                  r_busy    <= 1'b1;
                  r_ext_id  <= w_low_id;
               end else if (!w_eligible[r_cause[4:0]]) begin
                  r_state   <= IC_IDLE;
                  r_int_req <= 1'b0;
               end
            end
            IC_ACTIVE: begin
               if (mret_taken) begin
                  r_state <= IC_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state   <= IC_IDLE;
               r_int_req <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign int_req   = r_int_req;
   assign int_cause = r_cause;
   assign ext_id    = r_ext_id;
   assign busy      = r_busy;

endmodule
